hex_display_bank: RTL and testbench
===================================

# hex_display_bank

Parametrised multi-digit seven-segment display driver, the successor to our single-digit hex decoder. It latches a packed hex word plus per-digit enable and blink masks on a load strobe. It decodes every digit to active-low segments and blanks blinking digits on a programmable half-period. It sits between the experiment datapaths (counters, ALU results, FIFO status) and the board HEX pins.

## Interface
- `DIGITS`, default 6: number of digits driven, minimum 1.
- `BLINK_DIV`, default 25_000_000: blink half-period in clock cycles, minimum 1.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `load` in 1: latch `data`, `en` and `blink` on this rising edge.
- `data` in 4*DIGITS: packed nibbles; digit i is `data[4i+3:4i]`, digit 0 is least significant.
- `en` in DIGITS: per-digit display enable; 0 forces the digit blank.
- `blink` in DIGITS: per-digit blink select.
- `hex` out 7*DIGITS: registered segments; digit i is `hex[7i+6:7i]`, bit order g f e d c b a, active-low.
- `blink_phase` out 1: current blink phase; 1 means blinking digits are visible.

## Operation
- **Shadow registers** `data_q`, `en_q` and `blink_q` load only when `load`=1. Otherwise they hold.
- **Decode, per digit (gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Blank value** is 1111111.
- **Digit i is blank** when any of these holds:
  - `en_q[i]`=0;
  - `blink_q[i]`=1 and `blink_phase`=0;
  - the digit is leading-zero suppressed (only with the Configuration macro).
- **Blink counter** `cnt` has width max(1, clog2(BLINK_DIV)). It increments every cycle.
  - When `cnt`==BLINK_DIV-1: `cnt` wraps to 0 and `blink_phase` toggles.
  - BLINK_DIV=1 toggles the phase every cycle.
- **Load restarts blinking:** `load`=1 forces `cnt`=0 and `blink_phase`=1, overriding a coincident wrap or toggle. Newly loaded values are therefore always visible first.
- **Output register:** `hex` is recomputed every cycle from the shadow registers and `blink_phase`.

## Timing
- **Reset values:**
  - `hex` = all ones (every digit blank);
  - `blink_phase`=1;
  - `cnt`=0;
  - `data_q`, `en_q`, `blink_q` = 0.
- **Reset timing:** assertion takes effect immediately, asynchronously, including mid-blink. The first load is accepted on the first rising edge after deassertion.
- **Load latency:** `load` sampled at edge n updates the shadow registers at edge n. `hex` reflects the new values at edge n+1, i.e. 1 cycle of latency.
- **Back-to-back loads:** each is accepted. The last load wins, and `hex` follows one cycle behind each.
- **Phase timing:** with no further load after edge n, `blink_phase` toggles at edges n+k·BLINK_DIV for k≥1. `hex` blank/visible changes one edge after each toggle.
- **Unsampled inputs:** changes to `data`, `en` or `blink` while `load`=0 have no effect.

## Configuration
- `HEX_DISPLAY_LZS_EN` **defined:** leading-zero suppression is active.
  - Scanning from digit DIGITS-1 downward, a digit is suppressed while it and every higher digit have either latched value 0 or `en_q`=0.
  - The first nonzero enabled digit ends suppression.
  - Digit 0 is never suppressed.
  - Suppression is combinational on the shadow registers, so it keeps the same 1-cycle latency.
- `HEX_DISPLAY_LZS_EN` **undefined:** zero digits display as 1000000. There is no suppression logic.

## Test plan
Bench uses DIGITS=6, BLINK_DIV=4.
- **Reset:** assert `rst` between edges -> `hex`=42'h3FF_FFFF_FFFF and `blink_phase`=1 immediately, without waiting for a clock edge.
- **Load and decode:** `load` with `data`=24'h0123AF, `en`=6'h3F, `blink`=0 -> one edge later:
  - without macro: digits 5..0 = 1000000, 1111001, 0100100, 0110000, 0001000, 0001110;
  - with macro: digit 5 = 1111111, digits 4..0 unchanged.
- **Enable mask:** `en`=6'b111110, `data`=24'h888888 -> digit 0 = 1111111, digits 1–5 = 0000000.
- **Blink:** `blink`=6'b000001, `data`=24'h000005, `en`=6'h3F, load at edge n ->
  - digit 0 = 0010010 at edges n+1..n+4;
  - digit 0 blank at n+5..n+8;
  - digit 0 visible again at n+9;
  - `blink_phase` toggles at n+4 and n+8.
- **Reload mid-blank:** load during the blank half ->
  - `blink_phase`=1 at the load edge;
  - digit visible at the next edge;
  - the next toggle comes 4 edges after the load.
- **LZS zero value:** with macro, `data`=0 and `en`=6'h3F -> digit 0 = 1000000, digits 1–5 blank.

Source files
------------

// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment driver: latched hex word, per-digit enable/blink masks, active-low segments.
// Optional leading-zero suppression is built when HEX_DISPLAY_LZS_EN is defined.
module hex_display_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     blink,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  blink_phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   en_q;
  logic [DIGITS-1:0]   blink_q;
  logic [CNT_W-1:0]    cnt;
  logic [DIGITS-1:0]   suppress;
  logic [7*DIGITS-1:0] hex_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // load is a single-cycle strobe with no ready: every cycle it is high is accepted, last one wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      en_q    <= '0;
      blink_q <= '0;
    end else if (load) begin
      data_q  <= data;
      en_q    <= en;
      blink_q <= blink;
    end
  end

  // A load restarts the blink period so fresh values are always shown visible first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else if (load) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt         <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      cnt         <= cnt + CNT_W'(1);
    end
  end

`ifdef HEX_DISPLAY_LZS_EN
  always_comb begin : lzs_scan
    logic run;
    suppress = '0;
    run      = 1'b1;
    // Digit 0 is excluded so a value of zero still shows one 0.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (en_q[i] && (data_q[4*i +: 4] != 4'd0)) run = 1'b0;
      suppress[i] = run;
    end
  end
`else
  assign suppress = '0;
`endif

  always_comb begin
    hex_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (en_q[i] && !(blink_q[i] && !blink_phase) && !suppress[i])
        hex_next[7*i +: 7] = seg_decode(data_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hex <= '1;
    else     hex <= hex_next;
  end

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank (DIGITS=6, BLINK_DIV=4): directed test-plan cases plus
// random loads checked against a behavioural model of decode, masks, blink timing and optional LZS.
module tb_hex_display_bank;

  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;
  localparam int HW        = 7 * DIGITS;

  logic              clk;
  logic              rst;
  logic              load;
  logic [23:0]       data;
  logic [5:0]        en;
  logic [5:0]        blink;
  logic [HW-1:0]     hex;
  logic              blink_phase;

  hex_display_bank #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .en(en), .blink(blink),
    .hex(hex), .blink_phase(blink_phase)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [HW-1:0] exp_q[$];

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [23:0] sh_data;
  logic [5:0]  sh_en;
  logic [5:0]  sh_blink;
  int          since_load;
  logic        m_phase;

  task automatic check_eq(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] model_hex(input logic [23:0] d, input logic [5:0] e,
                                              input logic [5:0] b, input logic ph);
    logic [HW-1:0] r;
    int top;
    logic vis;
    r = '1;
    top = 0;
    for (int i = 0; i < DIGITS; i++)
      if (e[i] && d[4*i +: 4] != 4'd0) top = i;
    for (int i = 0; i < DIGITS; i++) begin
      vis = e[i] && !(b[i] && !ph);
`ifdef HEX_DISPLAY_LZS_EN
      if (i > top) vis = 1'b0;
`endif
      if (vis) r[7*i +: 7] = seg_tab[d[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic model_reset();
    sh_data = '0; sh_en = '0; sh_blink = '0;
    since_load = 0;
    m_phase = 1'b1;
  endtask

  // One clock edge: predict from pre-edge model state, advance the model, compare after the edge.
  task automatic tick();
    @(posedge clk);
    exp_q.push_back(model_hex(sh_data, sh_en, sh_blink, m_phase));
    if (load) begin
      sh_data = data; sh_en = en; sh_blink = blink;
      since_load = 0;
    end else begin
      since_load++;
    end
    m_phase = ((since_load / BLINK_DIV) % 2) == 0;
    #1;
    check_eq("hex", hex, exp_q.pop_front());
    check_eq("blink_phase", HW'(blink_phase), HW'(m_phase));
  endtask

  // driver tasks
  task automatic do_load(input logic [23:0] d, input logic [5:0] e, input logic [5:0] b);
    load = 1'b1; data = d; en = e; blink = b;
    tick();
    load = 1'b0;
  endtask

  task automatic idle();
    load = 1'b0;
    data = 24'($urandom); en = 6'($urandom); blink = 6'($urandom);
    tick();
  endtask

  logic [HW-1:0] exp_v;

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; en = '0; blink = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_hex", hex, {HW{1'b1}});
    check_eq("reset_phase", HW'(blink_phase), HW'(1'b1));
    rst = 1'b0;

    // load and decode
    do_load(24'h0123AF, 6'h3F, 6'h00);
    idle();
`ifdef HEX_DISPLAY_LZS_EN
    exp_v = {7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0001110};
`else
    exp_v = {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0001110};
`endif
    check_eq("decode_0123AF", hex, exp_v);

    // enable mask
    do_load(24'h888888, 6'b111110, 6'h00);
    idle();
    check_eq("en_mask", hex, {{5{7'b0000000}}, 7'b1111111});

    // blink timing, load at edge n
    do_load(24'h000005, 6'h3F, 6'b000001);
    check_eq("blink_phase_at_load", HW'(blink_phase), HW'(1'b1));
    for (int k = 1; k <= 9; k++) begin
      idle();
      check_eq("blink_digit0", HW'(hex[6:0]),
               HW'((k <= 4 || k >= 9) ? 7'b0010010 : 7'b1111111));
      check_eq("blink_phase_seq", HW'(blink_phase), HW'((k >= 4 && k < 8) ? 1'b0 : 1'b1));
    end

    // reload during the blank half
    do_load(24'h000005, 6'h3F, 6'b000001);
    repeat (5) idle();
    check_eq("blank_before_reload", HW'(hex[6:0]), HW'(7'b1111111));
    do_load(24'h000005, 6'h3F, 6'b000001);
    check_eq("reload_phase", HW'(blink_phase), HW'(1'b1));
    for (int k = 1; k <= 4; k++) begin
      idle();
      check_eq("reload_phase_seq", HW'(blink_phase), HW'((k == 4) ? 1'b0 : 1'b1));
      if (k == 1) check_eq("reload_visible", HW'(hex[6:0]), HW'(7'b0010010));
    end

    // zero value
    do_load(24'h000000, 6'h3F, 6'h00);
    idle();
`ifdef HEX_DISPLAY_LZS_EN
    check_eq("lzs_zero", hex, {{5{7'b1111111}}, 7'b1000000});
`else
    check_eq("zero_all", hex, {6{7'b1000000}});
`endif

    // random loads and unsampled input churn
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0)
        do_load(24'($urandom), 6'($urandom), 6'($urandom));
      else
        idle();
    end

    // asynchronous reset mid-blink, checked before any further edge
    do_load(24'h9ABCDE, 6'h3F, 6'h2A);
    repeat (5) idle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset_hex", hex, {HW{1'b1}});
    check_eq("async_reset_phase", HW'(blink_phase), HW'(1'b1));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    do_load(24'hFEDCBA, 6'h3F, 6'h00);
    idle();
    check_eq("first_load_after_reset", hex,
             {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
